// File: rtl/otter_pkg.sv
// Shared types for the MCU_Otter fetch stage: next-PC source select and fetch FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package otter_pkg;

    typedef enum logic [2:0] {
        PC_PLUS4  = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JAL    = 3'd3,
        PC_MTVEC  = 3'd4,
        PC_MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/otter_fetch_unit_if.sv
// Fetch-side bus bundle: the instruction-memory request/response and the decode-facing buffer.
// Latency: n/a (wiring only).
// Backpressure: ir_ready from decode gates new fetch requests in the master.
// Ports: imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata toward memory,
//        ir/ir_pc/ir_valid/ir_ready toward decode.
interface otter_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;

    // The fetch unit side.
    modport master (
        output imem_req, imem_addr, ir, ir_pc, ir_valid,
        input  imem_gnt, imem_rvalid, imem_rdata, ir_ready
    );

    // Memory plus decode side.
    modport slave (
        input  imem_req, imem_addr, ir, ir_pc, ir_valid,
        output imem_gnt, imem_rvalid, imem_rdata, ir_ready
    );

endinterface

// File: rtl/otter_pc_mux.sv
// Next-PC target select; outputs a word-aligned target plus a bit-1 misalignment flag.
// Latency: combinational.
// Backpressure: none.
// Ports: pc_source/pc and the five targets in; target (bits [1:0] cleared) and misaligned out.
// PC_MISALIGN_CHECK_EN: when defined, misaligned reports bit 1 of the selected target; otherwise it is 0.
module otter_pc_mux
    import otter_pkg::*;
(
    input  logic [2:0]  pc_source,
    input  logic [31:0] pc,
    input  logic [31:0] jal,
    input  logic [31:0] jalr,
    input  logic [31:0] branch,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] sel;

    always_comb begin
        sel = pc + 32'd4;
        case (pc_source)
            PC_JALR:   sel = jalr & ~32'd1;
            PC_BRANCH: sel = branch;
            PC_JAL:    sel = jal;
            PC_MTVEC:  sel = mtvec;
            PC_MEPC:   sel = mepc;
            default:   sel = pc + 32'd4;  // PC_PLUS4 and the unused codes 6/7
        endcase
    end

    assign target = sel & ~32'd3;

`ifdef PC_MISALIGN_CHECK_EN
    assign misaligned = sel[1];
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/otter_fetch_unit.sv
// PC register and single-outstanding instruction fetch into a one-entry valid/ready buffer.
// Latency: gnt at n, rvalid at n+k -> ir_valid at n+k+1; redirect at n -> new imem_addr at n+1.
// Backpressure: no request is issued unless the buffer is empty or being consumed this cycle.
// Ports: CLK/RST, PC_SOURCE + redirect + targets (jal/jalr/branch/mtvec/mepc), PC, misalign,
//        and the bus interface (imem request/response, ir buffer to decode).
// PC_MISALIGN_CHECK_EN: when defined, misalign pulses for one cycle after a redirect whose target has bit 1 set.
module otter_fetch_unit
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [2:0]         PC_SOURCE,
    input  logic               redirect,
    input  logic [31:0]        jal,
    input  logic [31:0]        jalr,
    input  logic [31:0]        branch,
    input  logic [31:0]        mtvec,
    input  logic [31:0]        mepc,
    output logic [31:0]        PC,
    output logic               misalign,
    otter_fetch_unit_if.master bus
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc_q, ir_q, ir_pc_q, target;
    logic         ir_valid_q, tgt_misaligned, fire, capture;

    otter_pc_mux u_pc_mux (
        .pc_source  (PC_SOURCE),
        .pc         (pc_q),
        .jal        (jal),
        .jalr       (jalr),
        .branch     (branch),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .target     (target),
        .misaligned (tgt_misaligned)
    );

    assign fire = bus.imem_req && bus.imem_gnt;
    // A redirect in the same cycle as rvalid drops the returning word.
    assign capture = (state == WAIT) && bus.imem_rvalid && !redirect;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= REQ;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            REQ:     if (fire) state_nx = WAIT;
            WAIT: begin
                if (bus.imem_rvalid) state_nx = REQ;
                else if (redirect)   state_nx = SQUASH;
            end
            SQUASH:  if (bus.imem_rvalid) state_nx = REQ;
            default: state_nx = REQ;
        endcase
    end

    // Output logic: only request when the buffer will have room for the reply.
    always_comb begin
        bus.imem_req = (state == REQ) && !RST && !redirect && (!ir_valid_q || bus.ir_ready);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q       <= RESET_ADDR;
            ir_q       <= 32'd0;
            ir_pc_q    <= 32'd0;
            ir_valid_q <= 1'b0;
        end else begin
            if (redirect)  pc_q <= target;
            else if (fire) pc_q <= pc_q + 32'd4;

            // PC already advanced at grant, so the fetched word belongs to PC-4.
            if (capture) begin
                ir_q       <= bus.imem_rdata;
                ir_pc_q    <= pc_q - 32'd4;
                ir_valid_q <= 1'b1;
            end else if (redirect || (ir_valid_q && bus.ir_ready)) begin
                ir_valid_q <= 1'b0;
            end
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    logic misalign_q;
    always_ff @(posedge CLK) begin
        if (RST) misalign_q <= 1'b0;
        else     misalign_q <= redirect && tgt_misaligned;
    end
    assign misalign = misalign_q;
`else
    // The mux ties its flag low in this build.
    assign misalign = tgt_misaligned;
`endif

    assign PC           = pc_q;
    assign bus.imem_addr = pc_q;
    assign bus.ir        = ir_q;
    assign bus.ir_pc     = ir_pc_q;
    assign bus.ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Directed bench for otter_fetch_unit with a latency-programmable instruction memory model.
module tb_otter_fetch_unit;
    import otter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  PC_SOURCE = 3'd0;
    logic        redirect = 1'b0;
    logic [31:0] jal = 32'd0, jalr = 32'd0, branch = 32'd0, mtvec = 32'd0, mepc = 32'd0;
    logic [31:0] PC;
    logic        misalign;
    int          n_checks = 0;
    int          n_fail = 0;
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] paddr;
    logic        exp_mis;

    otter_fetch_unit_if bus();

    otter_fetch_unit #(.RESET_ADDR(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .PC_SOURCE(PC_SOURCE), .redirect(redirect),
        .jal(jal), .jalr(jalr), .branch(branch), .mtvec(mtvec), .mepc(mepc),
        .PC(PC), .misalign(misalign), .bus(bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    // Memory: grant at n -> rvalid during n+lat. It deliberately ignores RST.
    always @(posedge CLK) begin
        if (bus.imem_req && bus.imem_gnt) begin
            paddr           <= bus.imem_addr;
            cnt             <= lat - 1;
            bus.imem_rvalid <= (lat == 1);
            bus.imem_rdata  <= (lat == 1) ? instr(bus.imem_addr) : 32'd0;
        end else begin
            bus.imem_rvalid <= (cnt == 1);
            bus.imem_rdata  <= (cnt == 1) ? instr(paddr) : 32'd0;
            if (cnt != 0) cnt <= cnt - 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        bus.ir_ready = 1'b1;
        bus.imem_gnt = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'd0;
        tick();
        tick();
        n_checks++; if (PC !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h exp 00000000", PC); end
        n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid got %b exp 0", bus.ir_valid); end
        n_checks++; if (bus.ir !== 32'd0 || bus.ir_pc !== 32'd0) begin n_fail++; $display("FAIL reset_ir got %h/%h exp 0/0", bus.ir, bus.ir_pc); end
        n_checks++; if (bus.imem_req !== 1'b0 || misalign !== 1'b0) begin n_fail++; $display("FAIL reset_req_mis got %b/%b exp 0/0", bus.imem_req, misalign); end
        RST = 1'b0;
    endtask

    task automatic test_fetch();
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4*i)) begin n_fail++; $display("FAIL fetch_req%0d got %b@%h exp 1@%h", i, bus.imem_req, bus.imem_addr, 32'(4*i)); end
            tick();
            n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_gap%0d ir_valid got %b exp 0", i, bus.ir_valid); end
            tick();
            n_checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'(4*i) || bus.ir !== instr(32'(4*i))) begin n_fail++; $display("FAIL fetch_ir%0d got %b %h %h exp 1 %h %h", i, bus.ir_valid, bus.ir_pc, bus.ir, 32'(4*i), instr(32'(4*i))); end
        end
    endtask

    task automatic test_backpressure();
        bus.ir_ready = 1'b0;
        #1;
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req got %b exp 0", bus.imem_req); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.imem_req !== 1'b0 || bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h8 || bus.ir !== instr(32'h8) || PC !== 32'hC) begin n_fail++; $display("FAIL bp_hold%0d got req %b v %b pc %h ir %h PC %h exp 0 1 8 %h c", i, bus.imem_req, bus.ir_valid, bus.ir_pc, bus.ir, PC, instr(32'h8)); end
        end
        bus.ir_ready = 1'b1;
        #1;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin n_fail++; $display("FAIL bp_release got %b@%h exp 1@0000000c", bus.imem_req, bus.imem_addr); end
        tick();
        tick();
        n_checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'hC) begin n_fail++; $display("FAIL bp_refill got %b %h exp 1 0000000c", bus.ir_valid, bus.ir_pc); end
    endtask

    task automatic test_squash();
        lat = 3;
        #1;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL sq_req got %b@%h exp 1@00000010", bus.imem_req, bus.imem_addr); end
        tick();                                   // granted, now waiting
        PC_SOURCE = 3'd3; jal = 32'h100; redirect = 1'b1;
        #1;
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL sq_redirect_req got %b exp 0", bus.imem_req); end
        tick();
        redirect = 1'b0; PC_SOURCE = 3'd0;
        #1;
        n_checks++; if (PC !== 32'h100 || bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b0 || bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL sq_wait got PC %h addr %h req %b v %b exp 100 100 0 0", PC, bus.imem_addr, bus.imem_req, bus.ir_valid); end
        tick();                                   // stale rvalid arrives here
        n_checks++; if (bus.imem_req !== 1'b0 || bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL sq_rvalid got req %b v %b exp 0 0", bus.imem_req, bus.ir_valid); end
        lat = 1;
        tick();
        n_checks++; if (bus.ir_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL sq_resume got v %b req %b addr %h exp 0 1 100", bus.ir_valid, bus.imem_req, bus.imem_addr); end
        tick();
        tick();
        n_checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h100 || bus.ir !== instr(32'h100)) begin n_fail++; $display("FAIL sq_target_ir got %b %h %h exp 1 100 %h", bus.ir_valid, bus.ir_pc, bus.ir, instr(32'h100)); end
    endtask

    task automatic test_jalr_misalign();
`ifdef PC_MISALIGN_CHECK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        PC_SOURCE = 3'd1; jalr = 32'h203; redirect = 1'b1;
        tick();
        redirect = 1'b0; PC_SOURCE = 3'd0;
        #1;
        n_checks++; if (PC !== 32'h200 || bus.imem_req !== 1'b1 || bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_pc got PC %h req %b v %b exp 200 1 0", PC, bus.imem_req, bus.ir_valid); end
        n_checks++; if (misalign !== exp_mis) begin n_fail++; $display("FAIL jalr_misalign got %b exp %b", misalign, exp_mis); end
        tick();
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL jalr_misalign_clear got %b exp 0", misalign); end
        tick();
        n_checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h200) begin n_fail++; $display("FAIL jalr_ir got %b %h exp 1 200", bus.ir_valid, bus.ir_pc); end
    endtask

    task automatic test_wrap();
        PC_SOURCE = 3'd4; mtvec = 32'hFFFF_FFFC; redirect = 1'b1;
        tick();
        redirect = 1'b0; PC_SOURCE = 3'd0;
        #1;
        n_checks++; if (PC !== 32'hFFFF_FFFC || bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_mtvec got %h/%h exp fffffffc", PC, bus.imem_addr); end
        tick();
        n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h exp 00000000", PC); end
        tick();
        n_checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'hFFFF_FFFC || bus.ir !== instr(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_ir got %b %h %h exp 1 fffffffc %h", bus.ir_valid, bus.ir_pc, bus.ir, instr(32'hFFFF_FFFC)); end
    endtask

    task automatic test_sources();
        logic [2:0]  srcs [5] = '{3'd2, 3'd5, 3'd6, 3'd0, 3'd7};
        logic [31:0] exps [5] = '{32'h80, 32'h44, 32'h48, 32'h4C, 32'h50};
        branch = 32'h80; mepc = 32'h44;
        redirect = 1'b1;
        for (int i = 0; i < 5; i++) begin
            PC_SOURCE = srcs[i];
            tick();
            n_checks++; if (PC !== exps[i] || misalign !== 1'b0) begin n_fail++; $display("FAIL src%0d got PC %h mis %b exp %h 0", srcs[i], PC, misalign, exps[i]); end
        end
        redirect = 1'b0; PC_SOURCE = 3'd0;
        #1;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h50) begin n_fail++; $display("FAIL src_req got %b@%h exp 1@00000050", bus.imem_req, bus.imem_addr); end
        tick();                                   // granted; rvalid present this cycle
        PC_SOURCE = 3'd3; jal = 32'h300; redirect = 1'b1;
        tick();
        redirect = 1'b0; PC_SOURCE = 3'd0;
        #1;
        n_checks++; if (PC !== 32'h300 || bus.ir_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin n_fail++; $display("FAIL wait_rvalid_redirect got PC %h v %b req %b addr %h exp 300 0 1 300", PC, bus.ir_valid, bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_reset_mid();
        lat = 3;
        tick();                                   // granted 0x300, waiting
        RST = 1'b1; bus.imem_gnt = 1'b0;
        #1;
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
        tick();
        n_checks++; if (PC !== 32'h0 || bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid got PC %h v %b exp 0 0", PC, bus.ir_valid); end
        RST = 1'b0;
        tick();                                   // stray rvalid visible now
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_req_after got %b@%h exp 1@00000000", bus.imem_req, bus.imem_addr); end
        tick();
        n_checks++; if (bus.ir_valid !== 1'b0 || PC !== 32'h0) begin n_fail++; $display("FAIL rst_stray got v %b PC %h exp 0 0", bus.ir_valid, PC); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_backpressure();
        test_squash();
        test_jalr_misalign();
        test_wrap();
        test_sources();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
